// File: rtl/execute_stage_md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_stage_md_pkg                                                       |
// | Shared encodings for the execute stage and its iterative mul/div unit.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package execute_stage_md_pkg;

  // M-extension funct3 encodings
  localparam logic [2:0] c_md_mul    = 3'd0;
  localparam logic [2:0] c_md_mulh   = 3'd1;
  localparam logic [2:0] c_md_mulhsu = 3'd2;
  localparam logic [2:0] c_md_mulhu  = 3'd3;
  localparam logic [2:0] c_md_div    = 3'd4;
  localparam logic [2:0] c_md_divu   = 3'd5;
  localparam logic [2:0] c_md_rem    = 3'd6;
  localparam logic [2:0] c_md_remu   = 3'd7;

  // ALUControl encodings
  localparam logic [2:0] c_alu_add = 3'd0;
  localparam logic [2:0] c_alu_sub = 3'd1;
  localparam logic [2:0] c_alu_and = 3'd2;
  localparam logic [2:0] c_alu_or  = 3'd3;
  localparam logic [2:0] c_alu_xor = 3'd4;
  localparam logic [2:0] c_alu_slt = 3'd5;
  localparam logic [2:0] c_alu_sll = 3'd6;
  localparam logic [2:0] c_alu_srl = 3'd7;

  // Branch funct3 encodings
  localparam logic [2:0] c_br_beq  = 3'd0;
  localparam logic [2:0] c_br_bne  = 3'd1;
  localparam logic [2:0] c_br_blt  = 3'd4;
  localparam logic [2:0] c_br_bge  = 3'd5;
  localparam logic [2:0] c_br_bltu = 3'd6;
  localparam logic [2:0] c_br_bgeu = 3'd7;

  // ResultSrc encodings
  localparam logic [1:0] c_res_alu = 2'd0;
  localparam logic [1:0] c_res_mem = 2'd1;
  localparam logic [1:0] c_res_pc4 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_stage_md_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_iter                                                                |
// | Radix-2 shift-add multiplier / restoring divider on magnitudes + sign fix. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module muldiv_iter
  import execute_stage_md_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MD_LAT_LOG2 = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  input  logic            i_accept,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam logic [MD_LAT_LOG2-1:0] c_last = MD_LAT_LOG2'(XLEN - 1);

  md_state_t              r_state, w_state_nxt;
  logic [MD_LAT_LOG2-1:0] r_cnt;
  logic [XLEN-1:0]        r_hi, r_lo, r_b;
  logic [2:0]             r_f3;
  logic                   r_neg, r_dz;

  logic                   w_sgn_a, w_sgn_b, w_neg_nxt;
  logic [XLEN-1:0]        w_abs_a, w_abs_b;
  logic [XLEN:0]          w_sum, w_shl;
  logic [XLEN-1:0]        w_diff;
  logic                   w_ge;
  logic [2*XLEN-1:0]      w_prod, w_prod_s;
  logic [XLEN-1:0]        w_quo, w_rem;

  // Which operands are treated as two's complement for this funct3
  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (i_funct3)
      c_md_mul, c_md_mulh, c_md_div, c_md_rem: begin
        w_sgn_a = i_a[XLEN-1];
        w_sgn_b = i_b[XLEN-1];
      end
      c_md_mulhsu: w_sgn_a = i_a[XLEN-1];
      default: ;
    endcase
  end

  assign w_abs_a   = w_sgn_a ? (~i_a + 1'b1) : i_a;
  assign w_abs_b   = w_sgn_b ? (~i_b + 1'b1) : i_b;
  assign w_neg_nxt = (i_funct3 == c_md_rem) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);

  // Multiply step: conditional add into the high half, then shift right
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // Divide step: shift remainder:quotient left, subtract divisor if it fits
  assign w_shl  = {r_hi, r_lo[XLEN-1]};
  assign w_ge   = (w_shl >= {1'b0, r_b});
  assign w_diff = w_shl[XLEN-1:0] - r_b;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_dz ? '1 : (r_neg ? (~r_lo + 1'b1) : r_lo);
  assign w_rem    = r_neg ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    o_result = '0;
    case (r_f3)
      c_md_mul:                           o_result = w_prod_s[XLEN-1:0];
      c_md_mulh, c_md_mulhsu, c_md_mulhu: o_result = w_prod_s[2*XLEN-1:XLEN];
      c_md_div, c_md_divu:                o_result = w_quo;
      default:                            o_result = w_rem;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start && !i_flush) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (i_flush)              w_state_nxt = S_IDLE;
        else if (r_cnt == c_last) w_state_nxt = S_DONE;
      end
      S_DONE: if (i_flush || i_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_f3    <= '0;
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_state_nxt == S_BUSY) begin
        r_hi  <= '0;
        r_lo  <= w_abs_a;
        r_b   <= w_abs_b;
        r_f3  <= i_funct3;
        r_neg <= w_neg_nxt;
        r_dz  <= ~|i_b;
        r_cnt <= '0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_f3[2]) begin
          r_hi <= w_ge ? w_diff : w_shl[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], w_ge};
        end else begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_busy = (r_state == S_BUSY);
  assign o_done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: rtl/execute_stage_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_stage_md                                                           |
// | Execute stage with ALU, branch resolution, iterative mul/div and E/M reg.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module execute_stage_md
  import execute_stage_md_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MD_LAT_LOG2 = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            Jalr,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            MulDivE,
  input  logic [2:0]      ALUControlE,
  input  logic [1:0]      ResultSrcE,
  input  logic            StallM,
  input  logic            FlushE,
  output logic            PCSrcE,
  output logic            JalrE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [31:0]     InstrM,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic            StallE
);

  localparam int SHW = $clog2(XLEN);

  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_srcb, w_alu, w_res, w_pc_target, w_md_result;
  logic            w_take, w_eq, w_lt, w_ltu;
  logic            w_md_busy, w_md_done, w_bubble;

  assign w_f3   = InstrE[14:12];
  assign w_srcb = ALUSrcE ? ImmExtE : RD2_E;

  always_comb begin
    w_alu = '0;
    case (ALUControlE)
      c_alu_add: w_alu = RD1_E + w_srcb;
      c_alu_sub: w_alu = RD1_E - w_srcb;
      c_alu_and: w_alu = RD1_E & w_srcb;
      c_alu_or:  w_alu = RD1_E | w_srcb;
      c_alu_xor: w_alu = RD1_E ^ w_srcb;
      c_alu_slt: w_alu = {{(XLEN-1){1'b0}}, $signed(RD1_E) < $signed(w_srcb)};
      c_alu_sll: w_alu = RD1_E << w_srcb[SHW-1:0];
      default:   w_alu = RD1_E >> w_srcb[SHW-1:0];
    endcase
  end

  // Branch comparison always uses the register operands
  assign w_eq  = (RD1_E == RD2_E);
  assign w_lt  = ($signed(RD1_E) < $signed(RD2_E));
  assign w_ltu = (RD1_E < RD2_E);

  always_comb begin
    w_take = 1'b0;
    case (w_f3)
      c_br_beq:  w_take = w_eq;
      c_br_bne:  w_take = ~w_eq;
      c_br_blt:  w_take = w_lt;
      c_br_bge:  w_take = ~w_lt;
      c_br_bltu: w_take = w_ltu;
      c_br_bgeu: w_take = ~w_ltu;
      default:   w_take = 1'b0;
    endcase
  end

  assign w_pc_target = PCE + ImmExtE;

  muldiv_iter #(
    .XLEN        (XLEN),
    .MD_LAT_LOG2 (MD_LAT_LOG2)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (MulDivE),
    .i_funct3 (w_f3),
    .i_a      (RD1_E),
    .i_b      (RD2_E),
    .i_flush  (FlushE),
    .i_accept (~StallM),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // Stall for the whole IDLE/BUSY span of a mul/div; release once DONE
  assign StallE   = MulDivE & ~FlushE & (w_md_busy | ~w_md_done);
  assign PCSrcE   = ((w_take & BranchE) | JumpE) & ~FlushE & ~StallE;
  assign w_res    = MulDivE ? w_md_result : w_alu;
  assign w_bubble = FlushE | StallE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      PCTargetE  <= '0;
      InstrM     <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      JalrE      <= 1'b0;
    end else if (StallM) begin
      ALUResultM <= ALUResultM;
    end else if (w_bubble) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      PCTargetE  <= '0;
      InstrM     <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      JalrE      <= 1'b0;
    end else begin
      ALUResultM <= w_res;
      WriteDataM <= RD2_E;
      PCPlus4M   <= PCPlus4E;
      PCTargetE  <= w_pc_target;
      InstrM     <= InstrE;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      JalrE      <= Jalr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_md.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_execute_stage_md                                                        |
// | Directed self-checking bench for execute_stage_md at XLEN = 32.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_execute_stage_md;
  import execute_stage_md_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     InstrE = '0;
  logic [XLEN-1:0] RD1_E = '0, RD2_E = '0, PCE = '0, ImmExtE = '0, PCPlus4E = '0;
  logic [4:0]      RdE = '0;
  logic            RegWriteE = 0, MemWriteE = 0, JumpE = 0, Jalr = 0, BranchE = 0;
  logic            ALUSrcE = 0, MulDivE = 0, StallM = 0, FlushE = 0;
  logic [2:0]      ALUControlE = '0;
  logic [1:0]      ResultSrcE = '0;
  logic            PCSrcE, JalrE, StallE, RegWriteM, MemWriteM;
  logic [XLEN-1:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [31:0]     InstrM;
  logic [4:0]      RdM;
  logic [1:0]      ResultSrcM;

  int n_chk = 0;
  int n_err = 0;

  execute_stage_md #(.XLEN(XLEN), .MD_LAT_LOG2(6)) dut (
    .clk(clk), .rst(rst), .InstrE(InstrE), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .Jalr(Jalr),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MulDivE(MulDivE),
    .ALUControlE(ALUControlE), .ResultSrcE(ResultSrcE), .StallM(StallM),
    .FlushE(FlushE), .PCSrcE(PCSrcE), .JalrE(JalrE), .PCTargetE(PCTargetE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .InstrM(InstrM), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .StallE(StallE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3);
    mk_instr = 32'h0200_0033 | ({29'd0, f3} << 12);
  endfunction

  task automatic nop();
    MulDivE = 0; RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
    Jalr = 0; FlushE = 0; ALUSrcE = 0; InstrE = 32'h0000_0013;
  endtask

  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    InstrE = mk_instr(f3); RD1_E = a; RD2_E = b; RdE = 5'd10;
    MulDivE = 1; RegWriteE = 1; ALUSrcE = 0; ResultSrcE = c_res_alu;
  endtask

  // Counts stalled cycles starting from the issue cycle; ends at negedge+1 of the first non-stalled cycle
  task automatic wait_ready(output int n);
    n = 0;
    #1;
    while (StallE && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic md_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int n;
    drive_md(f3, a, b);
    wait_ready(n);
    chk({tag, "_lat"}, 64'(n), 64'(XLEN + 1));
    @(posedge clk); #1;
    chk(tag, {32'd0, ALUResultM}, {32'd0, exp});
    chk({tag, "_rw"}, {63'd0, RegWriteM}, 64'd1);
    nop();
  endtask

  task automatic alu_op(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic src, input logic [31:0] exp);
    @(negedge clk);
    InstrE = 32'h0000_0033; RD1_E = a; RD2_E = src ? 32'h0 : b; ImmExtE = b;
    ALUSrcE = src; ALUControlE = ctl; RegWriteE = 1; RdE = 5'd7; MulDivE = 0;
    #1;
    chk({tag, "_stall"}, {63'd0, StallE}, 64'd0);
    @(posedge clk); #1;
    chk(tag, {32'd0, ALUResultM}, {32'd0, exp});
    nop();
  endtask

  initial begin
    int n;
    logic pcs_seen;
    logic hold_bad;

    #1;
    chk("rst_alu", {32'd0, ALUResultM}, 64'd0);
    chk("rst_rw", {63'd0, RegWriteM}, 64'd0);
    chk("rst_pct", {32'd0, PCTargetE}, 64'd0);
    @(negedge clk); rst = 0;

    // ALU path
    alu_op("add", c_alu_add, 32'd5, 32'd7, 1'b0, 32'd12);
    chk("add_rd", {59'd0, RdM}, 64'd7);
    chk("add_rw", {63'd0, RegWriteM}, 64'd1);
    alu_op("sub_imm", c_alu_sub, 32'd10, 32'd3, 1'b1, 32'd7);
    alu_op("slt", c_alu_slt, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1);

    // Branch / jump redirect and registered target
    @(negedge clk);
    InstrE = mk_instr(c_br_beq); RD1_E = 32'd9; RD2_E = 32'd9; BranchE = 1;
    PCE = 32'h100; ImmExtE = 32'h20; Jalr = 1; PCPlus4E = 32'h104;
    #1;
    chk("beq_take", {63'd0, PCSrcE}, 64'd1);
    @(posedge clk); #1;
    chk("pctarget", {32'd0, PCTargetE}, 64'h120);
    chk("jalr_reg", {63'd0, JalrE}, 64'd1);
    chk("pc4m", {32'd0, PCPlus4M}, 64'h104);
    InstrE = mk_instr(c_br_bne);
    #1;
    chk("bne_not", {63'd0, PCSrcE}, 64'd0);
    @(negedge clk);
    JumpE = 1; FlushE = 1;
    #1;
    chk("jump_flush", {63'd0, PCSrcE}, 64'd0);
    @(posedge clk); #1;
    chk("flush_jalr", {63'd0, JalrE}, 64'd0);
    nop();

    // Mul/div operations
    md_op("mul", c_md_mul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    md_op("mulh", c_md_mulh, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    md_op("mulhsu", c_md_mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_op("mulhu", c_md_mulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_op("div_ovf", c_md_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_op("rem_ovf", c_md_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    md_op("divu_z", c_md_divu, 32'd13, 32'd0, 32'hFFFF_FFFF);
    md_op("rem_z", c_md_rem, 32'd13, 32'd0, 32'd13);
    md_op("div_negz", c_md_div, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    md_op("div_neg", c_md_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_op("rem_neg", c_md_rem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_op("remu", c_md_remu, 32'd100, 32'd7, 32'd2);

    // Flush on cycle 5 of a DIV
    drive_md(c_md_div, 32'd100, 32'd7);
    for (int i = 1; i <= 5; i++) @(negedge clk);
    FlushE = 1;
    #1;
    chk("flush_stall", {63'd0, StallE}, 64'd0);
    @(posedge clk); #1;
    nop();
    chk("flush_bubble", {63'd0, RegWriteM}, 64'd0);
    #1;
    chk("flush_stall_after", {63'd0, StallE}, 64'd0);
    md_op("after_flush", c_md_divu, 32'd100, 32'd7, 32'd14);

    // Asynchronous reset in the middle of BUSY, with M held so it is nonzero
    alu_op("add2", c_alu_add, 32'd5, 32'd7, 1'b0, 32'd12);
    StallM = 1;
    drive_md(c_md_div, 32'd100, 32'd7);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1;
    #1;
    chk("arst_alu", {32'd0, ALUResultM}, 64'd0);
    chk("arst_instr", {32'd0, InstrM}, 64'd0);
    chk("arst_rd", {59'd0, RdM}, 64'd0);
    nop(); StallM = 0;
    @(negedge clk); rst = 0;
    md_op("divu_post_rst", c_md_divu, 32'd100, 32'd7, 32'd14);

    // StallM held at DONE; branch redirect masked while stalled
    alu_op("add3", c_alu_add, 32'd5, 32'd7, 1'b0, 32'd12);
    drive_md(c_md_mul, 32'd7, 32'd7);
    BranchE = 1; StallM = 1;
    pcs_seen = 0; hold_bad = 0;
    n = 0;
    #1;
    while (StallE && n < 200) begin
      pcs_seen = pcs_seen | PCSrcE;
      hold_bad = hold_bad | (ALUResultM != 32'd12);
      n++;
      @(negedge clk); #1;
    end
    chk("sm_lat", 64'(n), 64'(XLEN + 1));
    chk("sm_pcsrc_masked", {63'd0, pcs_seen}, 64'd0);
    chk("sm_hold_busy", {63'd0, hold_bad}, 64'd0);
    BranchE = 0;
    for (int k = 0; k < 3; k++) begin
      chk("sm_done_stall", {63'd0, StallE}, 64'd0);
      chk("sm_hold_done", {32'd0, ALUResultM}, 64'd12);
      @(negedge clk); #1;
    end
    StallM = 0;
    @(posedge clk); #1;
    chk("sm_release", {32'd0, ALUResultM}, 64'd49);
    nop();
    #1;
    chk("sm_idle_stall", {63'd0, StallE}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage with an integrated iterative multiply/divide unit (RV M-extension), pipeline stall/flush control and a registered E/M boundary. It sits between the decode/ID-EX register and the memory stage. It generalises the single-cycle execute stage in three ways: datapath width is a parameter, the E/M register honours stall and flush, and multi-cycle M-extension operations stall the front end until their result is ready.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- MD_LAT_LOG2, 6: width of the mul/div iteration counter; must satisfy 2^MD_LAT_LOG2 > XLEN.
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- InstrE, RD1_E, RD2_E, PCE, ImmExtE, PCPlus4E  in  XLEN each (InstrE 32)  operands and instruction from ID/EX.
- RdE  in  5  destination register.
- RegWriteE, MemWriteE, JumpE, Jalr, BranchE, ALUSrcE  in  1  decode controls.
- MulDivE  in  1  instruction is an M-extension op; funct3 = InstrE[14:12].
- ALUControlE  in  3  ALU op.
- ResultSrcE  in  2  writeback source select.
- StallM  in  1  downstream stall; hold the E/M register.
- FlushE  in  1  kill the instruction currently in E.
- PCSrcE, JalrE  out  1  redirect request and registered jalr flag.
- PCTargetE  out  XLEN  registered PC+imm.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  E/M register contents.
- InstrM  out  32;  RdM  out  5;  RegWriteM, MemWriteM  out  1;  ResultSrcM  out  2.
- StallE  out  1  mul/div busy; the hazard unit must freeze IF/ID/EX.

## Operation
- Non-MulDiv path: SrcB = ALUSrcE ? ImmExtE : RD2_E. Uses the existing alu, branching_unit and adder, widened to XLEN.
- PCSrcE = ((Takebranch & BranchE) | JumpE) & ~FlushE & ~StallE.
- Mul/div FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY when MulDivE & ~FlushE. In BUSY the unit latches operands as absolute values plus sign flags, according to funct3.
- BUSY: one shift-add or restoring-subtract step per cycle for exactly XLEN cycles, then -> DONE.
- DONE: fix up the sign, present the result, then -> IDLE once the E/M register accepts it (~StallM).
- StallE = MulDivE & (state != DONE) & ~FlushE. This freezes upstream, so InstrE/operands stay stable throughout.
- funct3 0..7 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. MUL returns the low XLEN bits of the 2·XLEN product; MULH* return the high XLEN bits.
- Divide by zero: quotient = all ones; remainder = dividend; no trap.
- Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- E/M register update, in priority order:
  - rst: all zero.
  - StallM: hold.
  - FlushE, or StallE: load a bubble, i.e. RegWriteM = MemWriteM = JalrE = 0, and the data fields take don't-care values.
  - otherwise: load. ALUResultM = the mul/div result when MulDivE, else the ALU result.
- FlushE while in BUSY or DONE: abort to IDLE the next cycle and discard the result.
- Reset: FSM = IDLE, counter = 0, every registered output = 0.

## Timing
- ALU ops: one cycle E->M, the same as the single-cycle stage.
- Mul/div: the instruction enters E at cycle 0. StallE is high for cycles 0..XLEN, i.e. XLEN+1 cycles. The result is registered into M at the edge ending cycle XLEN+1.
- If StallM is high in DONE, the FSM stays in DONE and StallE stays low. The result is held until StallM falls.
- Back-to-back mul/div: the second op sees IDLE on the cycle after acceptance, so there are no extra bubbles.
- PCSrcE is combinational from E inputs. Every output whose name ends in M is registered.

## Structure
- Shared package constants:
  - funct3 encodings MD_MUL..MD_REMU;
  - ALUControl encodings;
  - ResultSrc encodings;
  - FSM state enum (2 bits).
- One sub-module: muldiv_iter. It holds the FSM, counter, partial product/remainder registers and sign fix-up. Its interface is start, funct3, a, b, flush, accept; it returns busy, done and result.
- Top level: operand mux, alu, branching_unit, adder, result mux, E/M register.

## Test plan
All scenarios use XLEN = 32.
- ADD 5 + 7, no stall: ALUResultM = 12 one cycle later; StallE never rises.
- MUL 7 × 0xFFFFFFFD: StallE high for 33 cycles; then ALUResultM = 0xFFFFFFEB and RegWriteM = 1.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
- REM of the same operands gives 0.
- DIVU 13 / 0 gives 0xFFFFFFFF; REM 13 / 0 gives 13.
- FlushE pulsed on cycle 5 of a DIV: FSM is IDLE next cycle; M holds a bubble (RegWriteM = 0); StallE drops.
- rst asserted mid-BUSY: all outputs 0 asynchronously. A subsequent DIVU 100 / 7 returns 14 with full latency.
- StallM held 3 cycles at DONE: ALUResultM unchanged until release, then takes the result. PCSrcE stays 0 while StallE is high, even with BranchE & Takebranch.
